// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: operator/issue-package types and the decode/ALU-side bus of the issue buffer
package alu_issue_pkg;
  typedef enum logic [4:0] {
    ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, EQ, NE, LT, GE, LTU, GEU,
    MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU, MIN, MAX
  } operator_e;
  typedef struct packed {
    logic        valid;
    operator_e   instr;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_addr;
    logic        fwd_en;
  } alu_issue_s;
endpackage

interface alu_issue_buffer_if #(parameter int DEPTH = 4);
  import alu_issue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic             i_dec_valid;
  logic             o_dec_ready;
  operator_e        i_dec_instr;
  logic [31:0]      i_dec_operand_a;
  logic [31:0]      i_dec_operand_b;
  logic [4:0]       i_dec_rd_addr;
  logic             i_dec_fwd_en;
  logic             i_alu_ready;
  logic             i_invalidate;
  alu_issue_s       o_abt_alu_pkg;
  logic [CNT_W-1:0] o_count;
  modport slave (
    input  i_dec_valid, i_dec_instr, i_dec_operand_a, i_dec_operand_b, i_dec_rd_addr,
           i_dec_fwd_en, i_alu_ready, i_invalidate,
    output o_dec_ready, o_abt_alu_pkg, o_count
  );
  modport master (
    output i_dec_valid, i_dec_instr, i_dec_operand_a, i_dec_operand_b, i_dec_rd_addr,
           i_dec_fwd_en, i_alu_ready, i_invalidate,
    input  o_dec_ready, o_abt_alu_pkg, o_count
  );
endinterface

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: in-order FIFO of decoded ALU operations presented to the ALU, flushable on mispredict
module alu_issue_buffer
  import alu_issue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic                i_clk,
  input logic                i_rst_n,
  alu_issue_buffer_if.slave  bus
);
  alu_issue_s       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             vld, push, pop;
  assign vld             = (count != '0) & ~bus.i_invalidate;
  assign bus.o_dec_ready = (count != CNT_W'(DEPTH)) & ~bus.i_invalidate;
  assign push            = bus.i_dec_valid & bus.o_dec_ready;
  assign pop             = vld & bus.i_alu_ready;
  assign bus.o_count     = count;
  assign bus.o_abt_alu_pkg = vld ? mem[rd_ptr] : '0;
  // Storage write; x0 destinations are never marked forwardable
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= '{valid: 1'b1, instr: bus.i_dec_instr,
                               operand_a: bus.i_dec_operand_a, operand_b: bus.i_dec_operand_b,
                               rd_addr: bus.i_dec_rd_addr,
                               fwd_en: bus.i_dec_fwd_en & (bus.i_dec_rd_addr != '0)};
  // Pointer and occupancy update; invalidate empties the buffer and overrides push/pop
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_invalidate) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: directed stimulus with a queue scoreboard checking every cycle of the issue buffer
module tb_alu_issue_buffer;
  import alu_issue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  alu_issue_s exp_q[$];
  bit p;
  alu_issue_buffer_if #(.DEPTH(DEPTH)) bus();
  alu_issue_buffer #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input operator_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic fwd);
    bus.i_dec_valid     = 1'b1;
    bus.i_dec_instr     = op;
    bus.i_dec_operand_a = a;
    bus.i_dec_operand_b = b;
    bus.i_dec_rd_addr   = rd;
    bus.i_dec_fwd_en    = fwd;
  endtask

  task automatic cycle(output bit pushed);
    bit ev, er;
    @(negedge clk);
    ev = exp_q.size() != 0 && !bus.i_invalidate;
    er = exp_q.size() != DEPTH && !bus.i_invalidate;
    chk("count", bus.o_count, exp_q.size());
    chk("dec_ready", bus.o_dec_ready, er);
    if (ev) begin
      chk("issue", bus.o_abt_alu_pkg, exp_q[0]);
      if (bus.i_alu_ready) void'(exp_q.pop_front());
    end else chk("idle_pkg", bus.o_abt_alu_pkg, '0);
    pushed = bus.i_dec_valid && er;
    if (pushed)
      exp_q.push_back('{valid: 1'b1, instr: bus.i_dec_instr, operand_a: bus.i_dec_operand_a,
                        operand_b: bus.i_dec_operand_b, rd_addr: bus.i_dec_rd_addr,
                        fwd_en: bus.i_dec_fwd_en && bus.i_dec_rd_addr != 5'd0});
    if (bus.i_invalidate) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit q;
    for (int i = 0; i < n; i++) cycle(q);
  endtask

  task automatic push_one(input operator_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic fwd);
    bit q = 1'b0;
    offer(op, a, b, rd, fwd);
    for (int i = 0; i < 10 && !q; i++) cycle(q);
    chk("push_accepted", q, 1'b1);
    bus.i_dec_valid = 1'b0;
  endtask

  task automatic drain();
    bit q;
    bus.i_alu_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(q);
    chk("drained_count", bus.o_count, 0);
  endtask

  initial begin
    bus.i_dec_valid = 1'b0;
    bus.i_dec_instr = ADD;
    bus.i_dec_operand_a = '0;
    bus.i_dec_operand_b = '0;
    bus.i_dec_rd_addr = '0;
    bus.i_dec_fwd_en = 1'b0;
    bus.i_alu_ready = 1'b0;
    bus.i_invalidate = 1'b0;
    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", bus.o_count, 0);
    chk("rst_pkg", bus.o_abt_alu_pkg, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", bus.o_dec_ready, 1'b1);
    chk("rel_pkg", bus.o_abt_alu_pkg, '0);
    run(1);
    // single issue
    bus.i_alu_ready = 1'b1;
    push_one(ADD, 32'h5, 32'h7, 5'd3, 1'b1);
    chk("add_valid", bus.o_abt_alu_pkg.valid, 1'b1);
    chk("add_instr", bus.o_abt_alu_pkg.instr, ADD);
    chk("add_a", bus.o_abt_alu_pkg.operand_a, 32'h5);
    chk("add_b", bus.o_abt_alu_pkg.operand_b, 32'h7);
    chk("add_rd", bus.o_abt_alu_pkg.rd_addr, 5'd3);
    chk("add_fwd", bus.o_abt_alu_pkg.fwd_en, 1'b1);
    run(2);
    // fill, hold a fifth offer, then drain
    bus.i_alu_ready = 1'b0;
    push_one(SUB, 32'h11, 32'h12, 5'd4, 1'b1);
    push_one(XOR, 32'h21, 32'h22, 5'd5, 1'b0);
    push_one(SLL, 32'h31, 32'h32, 5'd6, 1'b1);
    push_one(SRA, 32'h41, 32'h42, 5'd7, 1'b1);
    chk("full_count", bus.o_count, 4);
    offer(MAX, 32'h51, 32'h52, 5'd8, 1'b1);
    run(2);
    chk("full_hold", bus.o_dec_ready, 1'b0);
    bus.i_alu_ready = 1'b1;
    push_one(MAX, 32'h51, 32'h52, 5'd8, 1'b1);
    drain();
    // steady state at count 2 with push and pop every cycle
    bus.i_alu_ready = 1'b0;
    push_one(MUL, 32'h100, 32'h200, 5'd9, 1'b1);
    push_one(DIV, 32'h101, 32'h201, 5'd10, 1'b1);
    bus.i_alu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(operator_e'(5'(i + 10)), 32'h1000 + i, 32'h2000 + i, 5'(i + 11), i[0]);
      cycle(p);
      chk("wrap_push", p, 1'b1);
      chk("wrap_count", bus.o_count, 2);
    end
    bus.i_dec_valid = 1'b0;
    drain();
    // invalidate with a concurrent push
    bus.i_alu_ready = 1'b0;
    push_one(SLT, 32'h7, 32'h8, 5'd12, 1'b1);
    push_one(SLTU, 32'h9, 32'ha, 5'd13, 1'b1);
    push_one(EQ, 32'hb, 32'hc, 5'd14, 1'b1);
    offer(NE, 32'hdead, 32'hbeef, 5'd15, 1'b1);
    bus.i_invalidate = 1'b1;
    bus.i_alu_ready = 1'b1;
    #1;
    chk("inv_valid", bus.o_abt_alu_pkg.valid, 1'b0);
    chk("inv_ready", bus.o_dec_ready, 1'b0);
    cycle(p);
    bus.i_invalidate = 1'b0;
    bus.i_dec_valid = 1'b0;
    chk("inv_count", bus.o_count, 0);
    run(3);
    // x0 destination is never forwarded
    push_one(OR, 32'h1, 32'h2, 5'd0, 1'b1);
    chk("x0_fwd", bus.o_abt_alu_pkg.fwd_en, 1'b0);
    run(2);
    // asynchronous reset in the middle of a cycle
    bus.i_alu_ready = 1'b0;
    push_one(AND, 32'h3, 32'h4, 5'd16, 1'b1);
    push_one(SRL, 32'h5, 32'h6, 5'd17, 1'b1);
    chk("pre_rst_count", bus.o_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", bus.o_count, 0);
    chk("mid_rst_valid", bus.o_abt_alu_pkg.valid, 1'b0);
    chk("mid_rst_pkg", bus.o_abt_alu_pkg, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.i_alu_ready = 1'b1;
    push_one(REM, 32'h77, 32'h88, 5'd18, 1'b1);
    chk("post_rst_rd", bus.o_abt_alu_pkg.rd_addr, 5'd18);
    run(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
